fft32_frame_ctrl: RTL
=====================

Name: fft32_frame_ctrl

Overview:
Frame sequencer in front of the 32-point FFT core.
- Collects ADC samples arriving serially with a valid/ready handshake into a 32-entry frame register.
- Presents the full frame in parallel to the FFT core and holds PU_enable high for the core's fixed pipeline latency.
- Captures all 32 complex results and drains them one bin per handshake to a downstream consumer.
- Single frame in flight; no input is accepted while computing or draining.

Parameters:
ADC_DATA_WIDTH, 8, width of one real ADC sample
DATA_WIDTH, 16, width of each FFT result real/imag word (Q8.8)
FFT_LATENCY, 4, clock edges from PU_enable rise to valid FFT_RESULT outputs; legal 1..255

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
s_valid  in  1  input sample valid
s_ready  out  1  controller accepts a sample
s_data  in  ADC_DATA_WIDTH  input sample
adc_frame  out  32*ADC_DATA_WIDTH  parallel frame to core; sample k at [k*ADC_DATA_WIDTH +: ADC_DATA_WIDTH]
PU_enable  out  1  core processing enable
fft_real  in  32*DATA_WIDTH  core real results; bin k at [k*DATA_WIDTH +: DATA_WIDTH]
fft_imag  in  32*DATA_WIDTH  core imag results, same packing
m_valid  out  1  output bin valid
m_ready  in  1  downstream accepts bin
m_real  out  DATA_WIDTH  real part of current bin
m_imag  out  DATA_WIDTH  imag part of current bin
m_index  out  5  bin number of current output
m_last  out  1  high with bin 31
frame_done  out  1  one-cycle pulse after bin 31 is accepted
busy  out  1  state != FILL

Behaviour:
- **Reset (reset=0, async):**
  - state=FILL, sample counter=0, latency counter=0, bin index=0.
  - adc_frame=0, captured result registers=0.
  - s_ready=0, PU_enable=0, m_valid=0, m_real=0, m_imag=0, m_index=0, m_last=0, frame_done=0, busy=0.
  - s_ready rises on the first clk edge after reset release.
  - Reset asserted mid-frame or mid-drain discards everything; no partial output follows.
- **All outputs are registered.**
- **FILL:**
  - s_ready=1.
  - Accept on edge with s_valid&s_ready: adc_frame slot[count] <= s_data; count++.
  - Accept at count=31 (32nd sample): on that same edge, count wraps to 0, state->COMPUTE, s_ready->0, PU_enable->1, busy->1.
  - s_valid=0 stalls indefinitely with no state change.
- **COMPUTE:**
  - adc_frame frozen; PU_enable=1.
  - Latency counter increments each edge.
  - On the FFT_LATENCY-th edge after PU_enable rose:
    - fft_real/fft_imag are sampled into capture registers.
    - PU_enable->0, state->DRAIN.
    - m_valid->1, m_index->0, m_real/m_imag = bin 0.
  - Latency counter clears.
- **DRAIN:**
  - m_real/m_imag/m_index/m_last remain stable while m_valid&!m_ready.
  - Handshake on m_valid&m_ready with index<31: index++, next bin presented on that edge (back-to-back, 1 bin/cycle max).
  - m_last = (index==31).
  - Handshake at index 31: m_valid->0, m_last->0, index->0, state->FILL, s_ready->1, busy->0, frame_done=1 for exactly that next cycle.
- **Timing and data rules:**
  - Minimum frame period = 32 + FFT_LATENCY + 32 cycles.
  - Core results are sampled only at capture; core output changes afterwards do not affect drained data.
  - Width rules: no arithmetic on data; samples and results pass bit-exact. Counters are 5-bit (samples, bins) and 8-bit (latency).
  - m_ready ignored when m_valid=0. s_valid ignored outside FILL; no sample is lost, since source must hold until s_ready.

Test Plan:
- **Ramp frame.** Reset low 50 ns, then ramp s_data=0..31 with s_valid=1 continuously.
  - adc_frame[8k+:8]=k.
  - PU_enable high for exactly 4 cycles starting the edge after sample 31.
  - s_ready=0 during COMPUTE/DRAIN.
- **Capture and drain, stub core.** Stub drives fft_real bin k=16'h0100*k and fft_imag bin k=16'hFF00|k; m_ready=1.
  - 32 consecutive beats, m_index 0..31.
  - Bin 5 yields m_real=16'h0500, m_imag=16'hFF05.
  - m_last only on beat 31; frame_done one cycle later.
- **Backpressure.** m_ready toggles 1,0,0,1 pattern.
  - Outputs stable while stalled.
  - All 32 bins delivered once, in order, no duplicates.
- **Input gaps.** s_valid deasserted randomly for 1-5 cycles during FILL with alternating 0/1 samples.
  - Frame contents exact.
  - PU_enable rises only after 32 accepts.
- **Reset mid-operation.** Assert reset in COMPUTE, then again in DRAIN at bin 10.
  - All outputs immediately at reset values.
  - Next full frame after release processes correctly from sample 0.
- **FFT_LATENCY=1 and 255.**
  - PU_enable pulse width equals the parameter.
  - Capture occurs on the correct edge: stub changes results one cycle before and after, and the bench verifies the correct snapshot.

Source files
------------

// File: rtl/fft32_frame_ctrl.sv
// fft32_frame_ctrl: gathers 32 serial ADC samples into a parallel frame,
// holds the FFT core enabled for its fixed latency, snapshots the 32 complex
// results and drains them one bin per valid/ready handshake.
module fft32_frame_ctrl #(
  parameter int ADC_DATA_WIDTH = 8,
  parameter int DATA_WIDTH     = 16,
  parameter int FFT_LATENCY    = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         s_valid,
  output logic                         s_ready,
  input  logic [ADC_DATA_WIDTH-1:0]    s_data,
  output logic [32*ADC_DATA_WIDTH-1:0] adc_frame,
  output logic                         PU_enable,
  input  logic [32*DATA_WIDTH-1:0]     fft_real,
  input  logic [32*DATA_WIDTH-1:0]     fft_imag,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic [DATA_WIDTH-1:0]        m_real,
  output logic [DATA_WIDTH-1:0]        m_imag,
  output logic [4:0]                   m_index,
  output logic                         m_last,
  output logic                         frame_done,
  output logic                         busy
);

  typedef enum logic [1:0] {
    FILL    = 2'd0,
    COMPUTE = 2'd1,
    DRAIN   = 2'd2
  } state_t;

  // Latency counter value seen on the edge that captures the core results.
  localparam logic [7:0] LAT_LAST = 8'(FFT_LATENCY - 1);

  state_t                    state;
  state_t                    state_nxt;
  logic [4:0]                sample_cnt;
  logic [7:0]                lat_cnt;
  logic [32*DATA_WIDTH-1:0]  cap_real;
  logic [32*DATA_WIDTH-1:0]  cap_imag;
  logic [4:0]                next_index;
  logic                      s_accept;
  logic                      lat_done;
  logic                      m_accept;
  logic                      last_accept;

  assign s_accept    = (state == FILL) && s_valid && s_ready;
  assign lat_done    = (state == COMPUTE) && (lat_cnt == LAT_LAST);
  assign m_accept    = (state == DRAIN) && m_valid && m_ready;
  assign last_accept = m_accept && (m_index == 5'd31);
  assign next_index  = m_index + 5'd1;

  // Next-state decode: fill -> compute after 32 accepts, compute -> drain at
  // capture, drain -> fill once bin 31 is taken.
  always_comb begin
    state_nxt = state;
    case (state)
      FILL:    if (s_accept && (sample_cnt == 5'd31)) state_nxt = COMPUTE;
      COMPUTE: if (lat_done) state_nxt = DRAIN;
      DRAIN:   if (last_accept) state_nxt = FILL;
      default: state_nxt = FILL;
    endcase
  end

  // State register plus the control outputs, registered from the next state
  // so they change on the same edge as the state itself.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= FILL;
      s_ready   <= 1'b0;
      PU_enable <= 1'b0;
      m_valid   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      s_ready   <= (state_nxt == FILL);
      PU_enable <= (state_nxt == COMPUTE);
      m_valid   <= (state_nxt == DRAIN);
      busy      <= (state_nxt != FILL);
    end
  end

  // Frame assembly, latency timing, result snapshot and bin sequencing.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sample_cnt <= '0;
      lat_cnt    <= '0;
      adc_frame  <= '0;
      cap_real   <= '0;
      cap_imag   <= '0;
      m_real     <= '0;
      m_imag     <= '0;
      m_index    <= '0;
      m_last     <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= last_accept;

      if (s_accept) begin
        adc_frame[int'(sample_cnt)*ADC_DATA_WIDTH +: ADC_DATA_WIDTH] <= s_data;
        sample_cnt <= sample_cnt + 5'd1;
      end

      if (state == COMPUTE) begin
        if (lat_done) begin
          lat_cnt  <= '0;
          cap_real <= fft_real;
          cap_imag <= fft_imag;
          m_real   <= fft_real[DATA_WIDTH-1:0];
          m_imag   <= fft_imag[DATA_WIDTH-1:0];
          m_index  <= '0;
          m_last   <= 1'b0;
        end else begin
          lat_cnt <= lat_cnt + 8'd1;
        end
      end

      if (m_accept) begin
        if (last_accept) begin
          m_index <= '0;
          m_last  <= 1'b0;
        end else begin
          m_index <= next_index;
          m_real  <= cap_real[int'(next_index)*DATA_WIDTH +: DATA_WIDTH];
          m_imag  <= cap_imag[int'(next_index)*DATA_WIDTH +: DATA_WIDTH];
          m_last  <= (next_index == 5'd31);
        end
      end
    end
  end

endmodule
